hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- ID-stage hazard and stall controller: the pipeline-control counterpart of EX-stage operand forwarding.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble for each.
- Freezes the whole pipeline while the data cache reports a miss, and flushes IF/ID on a taken branch.
- Holds a small FSM, a cache-wait watchdog counter and optional stall statistics.

Parameters:
- MAX_WAIT, 255: maximum consecutive cache-stall cycles before timeout_o sets; 0 disables the watchdog.
- CNT_W, 32: width of the optional stall statistic counters.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- ID_rs_1  in  5  rs1 of instruction in ID
- ID_rs_2  in  5  rs2 of instruction in ID
- EX_MemRead  in  1  instruction in EX is a load
- EX_rd  in  5  destination of instruction in EX
- ID_branch_taken  in  1  branch in ID resolved taken
- mem_stall_i  in  1  data cache busy (miss in service)
- PC_write_o  out  1  PC update enable
- IFID_write_o  out  1  IF/ID register write enable
- IDEX_bubble_o  out  1  load NoOp control into ID/EX
- IFID_flush_o  out  1  clear IF/ID to NoOp
- pipe_stall_o  out  1  freeze PC and all pipeline registers
- timeout_o  out  1  sticky watchdog flag
- state_o  out  2  current FSM state, for debug
- lu_cnt_o  out  CNT_W  load-use bubbles inserted (optional)
- mem_cnt_o  out  CNT_W  cache-freeze cycles (optional)

Behaviour:
- Reset (rst_i=0 at clk edge): state=RUN, wait counter=0, timeout_o=0, counters=0.
- While rst_i=0: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=0, IFID_flush_o=0, pipe_stall_o=0.
- Reset mid-MEM_WAIT aborts the wait and clears the counter on that edge.
- load_use = EX_MemRead && EX_rd!=0 && (EX_rd==ID_rs_1 || EX_rd==ID_rs_2).
- Control outputs are combinational from state and live inputs, so they act in the same cycle. The FSM registers at each edge.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2.
- Default outputs: PC_write_o=1, IFID_write_o=1, all others 0.
- Priority in every state: freeze > bubble > flush.
- RUN:
  - mem_stall_i=1 -> pipe_stall_o=1, PC_write_o=0, IFID_write_o=0; next MEM_WAIT; wait counter=1.
  - else load_use -> PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; next LU_STALL.
  - else ID_branch_taken -> IFID_flush_o=1; stay RUN.
- LU_STALL (one cycle; the held instruction re-decodes against the bubble in EX):
  - mem_stall_i=1 -> freeze as in RUN; next MEM_WAIT.
  - else load_use is ignored (no back-to-back bubble); ID_branch_taken flushes; next RUN.
- MEM_WAIT:
  - mem_stall_i=1 -> freeze; wait counter increments, saturating at MAX_WAIT.
  - Counter reaching MAX_WAIT (MAX_WAIT≠0) sets timeout_o. timeout_o stays set until reset.
  - mem_stall_i=0 -> release cycle: no freeze; load_use and branch are evaluated from live inputs exactly as in RUN, including the next-state choice; wait counter=0.
- Simultaneous mem_stall_i with load_use or branch: only the freeze acts. Frozen ID/EX inputs persist, so the deferred hazard or flush is re-evaluated on the release cycle.
- The freeze never asserts IDEX_bubble_o or IFID_flush_o.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - lu_cnt_o increments on each cycle with IDEX_bubble_o=1.
  - mem_cnt_o increments on each cycle with pipe_stall_o=1.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both ports are still present, tied to 0; no counter flops.

Test Plan:
- Load x5 in EX (EX_MemRead=1, EX_rd=5); ID_rs_2=5 -> same cycle PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; next cycle state_o=1, all defaults; then state_o=0.
- EX_rd=0 with EX_MemRead=1 and ID_rs_1=0 -> no bubble, state stays RUN.
- mem_stall_i high 4 cycles, then low -> pipe_stall_o=1 for exactly 4 cycles, state_o=2 from cycle 2; release cycle PC_write_o=1; mem_cnt_o=4 with HAZARD_STALL_CNT_EN.
- mem_stall_i=1 together with ID_branch_taken=1 for 3 cycles, then low with branch still 1 -> no flush while frozen; IFID_flush_o=1 only on the release cycle.
- MAX_WAIT=8, mem_stall_i held 20 cycles -> timeout_o rises on the 8th stall cycle and stays 1 after release until rst_i=0.
- rst_i=0 asserted during MEM_WAIT -> next edge state_o=0, timeout_o=0, counters 0; outputs inactive while reset is held.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: groups the ID/EX hazard inputs and the pipeline control
// outputs of hazard_stall_unit.
//   master : pipeline side; drives the ID/EX fields and the cache busy flag,
//            and observes the control outputs.
//   slave  : hazard_stall_unit; consumes the fields and drives the controls.
// Parameter CNT_W sets the width of the stall statistic outputs.
interface hazard_stall_unit_if #(parameter int CNT_W = 32);
  logic [4:0]       ID_rs_1;
  logic [4:0]       ID_rs_2;
  logic             EX_MemRead;
  logic [4:0]       EX_rd;
  logic             ID_branch_taken;
  logic             mem_stall_i;
  logic             PC_write_o;
  logic             IFID_write_o;
  logic             IDEX_bubble_o;
  logic             IFID_flush_o;
  logic             pipe_stall_o;
  logic             timeout_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] lu_cnt_o;
  logic [CNT_W-1:0] mem_cnt_o;

  modport master (
    output ID_rs_1, ID_rs_2, EX_MemRead, EX_rd, ID_branch_taken, mem_stall_i,
    input  PC_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o, pipe_stall_o,
           timeout_o, state_o, lu_cnt_o, mem_cnt_o
  );

  modport slave (
    input  ID_rs_1, ID_rs_2, EX_MemRead, EX_rd, ID_branch_taken, mem_stall_i,
    output PC_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o, pipe_stall_o,
           timeout_o, state_o, lu_cnt_o, mem_cnt_o
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage hazard / stall controller.
//   - one bubble per load-use hazard that forwarding cannot cover
//   - whole-pipeline freeze while the data cache reports a miss
//   - IF/ID flush on a taken branch
//   Priority: freeze > bubble > flush. Controls are combinational from the
//   current state and the live inputs; the FSM registers on each edge.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous active-low reset; all controls forced inactive while low
//   bus     hazard_stall_unit_if.slave (ID/EX fields in, controls/debug out)
// Parameters:
//   MAX_WAIT  consecutive freeze cycles before sticky timeout_o (0 = off)
//   CNT_W     width of the stall statistic counters
// Optional feature macro: HAZARD_STALL_CNT_EN
//   defined   -> lu_cnt_o / mem_cnt_o count bubble / freeze cycles (wrapping)
//   undefined -> both outputs tied to 0, no counter flops
module hazard_stall_unit #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_stall_unit_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

  // Counter is wide enough for MAX_WAIT; with the watchdog off it only ever
  // needs to hold 1, which keeps it a legal one-bit register.
  localparam int           WW   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WCAP = WW'((MAX_WAIT == 0) ? 1 : MAX_WAIT);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;

  logic load_use;
  logic pc_w, ifid_w, bubble, flush, freeze;

  assign load_use = bus.EX_MemRead && (bus.EX_rd != 5'd0) &&
                    ((bus.EX_rd == bus.ID_rs_1) || (bus.EX_rd == bus.ID_rs_2));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    bubble    = 1'b0;
    flush     = 1'b0;
    freeze    = 1'b0;
    if (bus.mem_stall_i) begin
      // Freeze masks any pending hazard/branch; ID/EX are held, so they are
      // re-evaluated on the release cycle.
      freeze  = 1'b1;
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      state_d = MEM_WAIT;
      if (state_q == MEM_WAIT)
        wait_d = (wait_q >= WCAP) ? WCAP : wait_q + 1'b1;
      else
        wait_d = WW'(1);
    end else begin
      // RUN and the MEM_WAIT release cycle behave identically; LU_STALL only
      // suppresses a second bubble for the re-decoded instruction.
      wait_d  = '0;
      state_d = RUN;
      if (load_use && state_q != LU_STALL) begin
        bubble  = 1'b1;
        pc_w    = 1'b0;
        ifid_w  = 1'b0;
        state_d = LU_STALL;
      end else if (bus.ID_branch_taken) begin
        flush = 1'b1;
      end
    end
    timeout_d = timeout_q;
    if (MAX_WAIT != 0 && freeze && wait_d == WCAP) timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.PC_write_o    = rst_i & pc_w;
  assign bus.IFID_write_o  = rst_i & ifid_w;
  assign bus.IDEX_bubble_o = rst_i & bubble;
  assign bus.IFID_flush_o  = rst_i & flush;
  assign bus.pipe_stall_o  = rst_i & freeze;
  assign bus.timeout_o     = timeout_q;
  assign bus.state_o       = state_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (bubble) lu_cnt_q  <= lu_cnt_q + 1'b1;
      if (freeze) mem_cnt_q <= mem_cnt_q + 1'b1;
    end
  end

  assign bus.lu_cnt_o  = lu_cnt_q;
  assign bus.mem_cnt_o = mem_cnt_q;
`else
  assign bus.lu_cnt_o  = '0;
  assign bus.mem_cnt_o = '0;
`endif

endmodule
